lsu_mem_master: RTL and testbench
=================================

# lsu_mem_master

Load/store initiator between the execute stage and `data_memory`. Accepts one load or store request per handshake and decodes RV32 funct3 into memory enables, byte mask and sub-word address. Drives the memory's combinational-read / clocked-write port, then returns the sign- or zero-extended load result to the pipeline. Misaligned halfword and word accesses are split into byte accesses by a small FSM.

## Interface
Parameters:
- none; widths come from `defines.sv` (`MEM_ADDR_WIDTH`, `REG_DATA_WIDTH` = 32, `MASK_WIDTH`, `MASK_B/H/W`).

Ports. One clock; reset is synchronous and active-low.
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 load/store funct3
- req_addr  in  `MEM_ADDR_WIDTH`  byte address
- req_wdata  in  32  store data (low bytes used for SB/SH)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal funct3 or misaligned access (when not split)
- mem_rd_en / mem_wr_en  out  1  memory read / write enable
- mem_mask  out  `MASK_WIDTH`  `MASK_B/H/W`
- mem_addr  out  `MEM_ADDR_WIDTH`  memory byte address
- mem_wr_data  out  32  store data, right-aligned
- mem_rd_data  in  32  combinational read data, right-aligned, zero-extended

## Operation
- Request accepted when req_valid && req_ready. Latch we, funct3, addr and wdata.
- Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- Any other code is illegal. It completes with resp_err=1, resp_rdata=0 and no memory enable.
- Aligned when addr[0]=0 for H and addr[1:0]=0 for W; B is always aligned.
- FSM states: IDLE, ACCESS, SPLIT, RESP.
  - IDLE -> ACCESS: aligned or illegal request accepted.
  - IDLE -> SPLIT: misaligned request accepted and split enabled.
  - ACCESS -> RESP, always.
  - SPLIT -> RESP after the last byte.
  - RESP -> IDLE, always.
- ACCESS drives one access:
  - mask `MASK_B/H/W`, mem_addr = latched addr.
  - mem_rd_en = !we, mem_wr_en = we.
  - mem_wr_data = wdata.
  - Load data is captured into the result register at the end of this cycle.
- SPLIT drives N byte accesses (N=2 for H, N=4 for W), one per cycle, using a 2-bit byte counter k:
  - mem_mask = `MASK_B`, mem_addr = addr + k, modulo 2^`MEM_ADDR_WIDTH` (wraps).
  - Store: mem_wr_data = {24'b0, wdata[8k+7:8k]}.
  - Load: mem_rd_data[7:0] is captured into result byte k.
- Load extension in RESP:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- All mem_* outputs are 0 in IDLE and RESP.

## Timing
- Reset (rst=0 at posedge): state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all mem_* = 0, counter=0.
- Reset mid-operation aborts the access with no response. A store byte already written stays written.
- Request accepted at cycle T:
  - Aligned or illegal: ACCESS at T+1, resp_valid at T+2.
  - Misaligned: bytes at T+1..T+N, resp_valid at T+N+1.
- resp_valid is high for exactly one cycle. There is no response backpressure. resp_rdata and resp_err are valid only while resp_valid=1 and are 0 otherwise.
- req_ready=0 from T+1 through the RESP cycle. The next request can be accepted the cycle after RESP.
- Store data is committed by memory at the end of the ACCESS or SPLIT cycle. A load issued on the following request reads the new value.

## Configuration
- `LSU_MISALIGN_EN` defined: misaligned H/W accesses go through SPLIT as above.
- `LSU_MISALIGN_EN` undefined:
  - SPLIT logic and the counter are omitted.
  - Misaligned requests take the ACCESS path with both enables held 0.
  - They complete at T+2 with resp_err=1 and resp_rdata=0.

## Test plan
- Preload word 0x8000_1234 at 0x10. LW 0x10: one read with `MASK_W`; resp at T+2, rdata=0x8000_1234, err=0.
- Same word, LB 0x13 -> rdata 0xFFFF_FF80. LBU 0x13 -> 0x0000_0080. LH 0x12 -> 0xFFFF_8000.
- SH wdata 0xABCD at 0x12 (`MASK_H`, one write), then LW 0x10 -> 0xABCD_1234.
- Misaligned LW 0x11 (macro on), bytes 0x11..0x14 = 11,22,33,44:
  - four `MASK_B` reads at addrs 0x11..0x14 in T+1..T+4;
  - resp at T+5 with rdata 0x4433_2211.
- Misaligned SW 0x11 with macro off: no enable asserted, resp at T+2 with err=1; memory unchanged. Same check for illegal funct3 011.
- Reset asserted at T+2 of a split SW 0x11: no resp; mem_* = 0 and req_ready=1 next cycle; only byte 0x11 updated.

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store initiator: decodes RV32 funct3, drives a comb-read/clocked-write memory port, returns extended load data.
// Optional feature macro LSU_MISALIGN_EN splits misaligned H/W accesses into byte accesses.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH 4
`define MASK_B 4'b0001
`define MASK_H 4'b0011
`define MASK_W 4'b1111
`endif

module lsu_mem_master (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_we,
  input  logic [2:0]                  req_funct3,
  input  logic [`MEM_ADDR_WIDTH-1:0]  req_addr,
  input  logic [`REG_DATA_WIDTH-1:0]  req_wdata,
  output logic                        resp_valid,
  output logic [`REG_DATA_WIDTH-1:0]  resp_rdata,
  output logic                        resp_err,
  output logic                        mem_rd_en,
  output logic                        mem_wr_en,
  output logic [`MASK_WIDTH-1:0]      mem_mask,
  output logic [`MEM_ADDR_WIDTH-1:0]  mem_addr,
  output logic [`REG_DATA_WIDTH-1:0]  mem_wr_data,
  input  logic [`REG_DATA_WIDTH-1:0]  mem_rd_data
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_SPLIT  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]                 state;
  logic                       we_q;
  logic                       err_q;
  logic [2:0]                 funct3_q;
  logic [`MEM_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]                wdata_q;
  logic [31:0]                result_q;

  logic accept;
  logic req_legal;
  logic req_misaligned;

  assign accept = req_valid && req_ready;

  always_comb begin
    if (req_we) req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    else        req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                     ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

`ifdef LSU_MISALIGN_EN
  logic [1:0] k;
  logic [1:0] k_last;
  assign k_last = (funct3_q[1:0] == 2'b01) ? 2'd1 : 2'd3;
`endif

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] r);
    case (f3)
      3'b000:  return {{24{r[7]}}, r[7:0]};
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b100:  return {24'b0, r[7:0]};
      3'b101:  return {16'b0, r[15:0]};
      default: return r;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
`ifdef LSU_MISALIGN_EN
      k        <= 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          we_q     <= req_we;
          funct3_q <= req_funct3;
          addr_q   <= req_addr;
          wdata_q  <= req_wdata;
          result_q <= '0;
`ifdef LSU_MISALIGN_EN
          err_q    <= !req_legal;
          state    <= (req_legal && req_misaligned) ? S_SPLIT : S_ACCESS;
`else
          // Without splitting, a misaligned access is reported as an error.
          err_q    <= !req_legal || req_misaligned;
          state    <= S_ACCESS;
`endif
        end
        S_ACCESS: begin
          if (!we_q && !err_q) result_q <= mem_rd_data;
          state <= S_RESP;
        end
`ifdef LSU_MISALIGN_EN
        S_SPLIT: begin
          if (!we_q) result_q[{k, 3'b000} +: 8] <= mem_rd_data[7:0];
          if (k == k_last) begin
            k     <= 2'd0;
            state <= S_RESP;
          end else begin
            k <= k + 2'd1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    req_ready   = (state == S_IDLE);
    resp_valid  = 1'b0;
    resp_rdata  = '0;
    resp_err    = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_mask    = '0;
    mem_addr    = '0;
    mem_wr_data = '0;
    case (state)
      S_ACCESS: if (!err_q) begin
        mem_rd_en   = !we_q;
        mem_wr_en   = we_q;
        mem_addr    = addr_q;
        mem_wr_data = wdata_q;
        case (funct3_q[1:0])
          2'b00:   mem_mask = `MASK_B;
          2'b01:   mem_mask = `MASK_H;
          default: mem_mask = `MASK_W;
        endcase
      end
`ifdef LSU_MISALIGN_EN
      S_SPLIT: begin
        mem_rd_en   = !we_q;
        mem_wr_en   = we_q;
        mem_mask    = `MASK_B;
        mem_addr    = addr_q + {{(`MEM_ADDR_WIDTH-2){1'b0}}, k};
        mem_wr_data = {24'b0, wdata_q[{k, 3'b000} +: 8]};
      end
`endif
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? 32'b0 : extend(funct3_q, result_q);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: table of directed requests plus hand sequences for split and reset corners.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 16
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef MASK_WIDTH
`define MASK_WIDTH 4
`define MASK_B 4'b0001
`define MASK_H 4'b0011
`define MASK_W 4'b1111
`endif

module tb_lsu_mem_master;
  localparam int AW = `MEM_ADDR_WIDTH;
  localparam int MW = `MASK_WIDTH;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [2:0]    req_funct3 = 3'b000;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          mem_rd_en, mem_wr_en;
  logic [MW-1:0] mem_mask;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data;
  logic [31:0]   mem_rd_data;

  lsu_mem_master dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_mask(mem_mask),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  // Byte memory: combinational read, clocked write, plus a bench preload port.
  logic [7:0] mem [256];
  logic       pl_we = 1'b0;
  logic       pl_clr = 1'b0;
  logic [7:0] pl_addr = '0;
  logic [7:0] pl_data = '0;
  logic [7:0] ma;
  assign ma = mem_addr[7:0];

  always_comb begin
    mem_rd_data = 32'b0;
    for (int i = 0; i < 4; i++)
      if (mem_mask[i]) mem_rd_data[8*i +: 8] = mem[ma + 8'(i)];
  end

  always @(posedge clk) begin
    if (pl_clr) for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    else if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_wr_en)
      for (int i = 0; i < 4; i++)
        if (mem_mask[i]) mem[ma + 8'(i)] <= mem_wr_data[8*i +: 8];
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk); pl_we = 1'b0;
  endtask

  typedef struct {
    string         name;
    bit            we;
    logic [2:0]    f3;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   exp_rdata;
    bit            exp_err;
    int            exp_lat;
    int            exp_rd;
    int            exp_wr;
    logic [MW-1:0] exp_mask;
  } vec_t;

  function automatic vec_t mk(string n, bit we, logic [2:0] f3, int addr, logic [31:0] wd,
                              logic [31:0] er, bit ee, int lat, int rd, int wr, logic [MW-1:0] m);
    vec_t v;
    v.name = n; v.we = we; v.f3 = f3; v.addr = addr[AW-1:0]; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr; v.exp_mask = m;
    return v;
  endfunction

  logic [AW-1:0] log_addr [8];
  logic [MW-1:0] log_mask [8];

  // Issues one request, records the memory accesses it makes and checks the response.
  task automatic run(input vec_t v);
    int lat = 0, rd = 0, wr = 0, nacc = 0, early_ready = 0;
    logic [31:0] rdata = '0;
    logic err = 1'b0;
    @(negedge clk);
    check({v.name, "_ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 10 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_rd_en) rd++;
      if (mem_wr_en) wr++;
      if ((mem_rd_en || mem_wr_en) && nacc < 8) begin
        log_addr[nacc] = mem_addr; log_mask[nacc] = mem_mask; nacc++;
      end
      if (req_ready) early_ready++;
      if (resp_valid) begin lat = c; rdata = resp_rdata; err = resp_err; end
    end
    if (lat == 0) begin
      bad++; total++;
      $display("FAIL %s_timeout: got no resp_valid expected one within 10 cycles", v.name);
    end else begin
      check({v.name, "_lat"}, 32'(lat), 32'(v.exp_lat));
      check({v.name, "_rdata"}, rdata, v.exp_rdata);
      check({v.name, "_err"}, {31'b0, err}, {31'b0, v.exp_err});
    end
    check({v.name, "_rd_cnt"}, 32'(rd), 32'(v.exp_rd));
    check({v.name, "_wr_cnt"}, 32'(wr), 32'(v.exp_wr));
    check({v.name, "_busy"}, 32'(early_ready), 32'd0);
    if (nacc > 0) check({v.name, "_mask"}, 32'(log_mask[0]), 32'(v.exp_mask));
    @(negedge clk);
    check({v.name, "_pulse"}, {30'b0, resp_valid, req_ready}, 32'b01);
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back(mk("lw10",   1'b0, 3'b010, 'h10, 32'h0,        32'h8000_1234, 1'b0, 2, 1, 0, `MASK_W));
    vecs.push_back(mk("lb13",   1'b0, 3'b000, 'h13, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 1, 0, `MASK_B));
    vecs.push_back(mk("lbu13",  1'b0, 3'b100, 'h13, 32'h0,        32'h0000_0080, 1'b0, 2, 1, 0, `MASK_B));
    vecs.push_back(mk("lh12",   1'b0, 3'b001, 'h12, 32'h0,        32'hFFFF_8000, 1'b0, 2, 1, 0, `MASK_H));
    vecs.push_back(mk("lhu12",  1'b0, 3'b101, 'h12, 32'h0,        32'h0000_8000, 1'b0, 2, 1, 0, `MASK_H));
    vecs.push_back(mk("lb10",   1'b0, 3'b000, 'h10, 32'h0,        32'h0000_0034, 1'b0, 2, 1, 0, `MASK_B));
    vecs.push_back(mk("sh12",   1'b1, 3'b001, 'h12, 32'h1111_ABCD, 32'h0,        1'b0, 2, 0, 1, `MASK_H));
    vecs.push_back(mk("lw10b",  1'b0, 3'b010, 'h10, 32'h0,        32'hABCD_1234, 1'b0, 2, 1, 0, `MASK_W));
    vecs.push_back(mk("sb11",   1'b1, 3'b000, 'h11, 32'h7777_77EE, 32'h0,        1'b0, 2, 0, 1, `MASK_B));
    vecs.push_back(mk("lw10c",  1'b0, 3'b010, 'h10, 32'h0,        32'hABCD_EE34, 1'b0, 2, 1, 0, `MASK_W));
    vecs.push_back(mk("ill_l3", 1'b0, 3'b011, 'h10, 32'h0,        32'h0,         1'b1, 2, 0, 0, `MASK_W));
    vecs.push_back(mk("ill_s4", 1'b1, 3'b100, 'h10, 32'hFFFF_FFFF, 32'h0,        1'b1, 2, 0, 0, `MASK_W));
    vecs.push_back(mk("ill_s3", 1'b1, 3'b011, 'h10, 32'hFFFF_FFFF, 32'h0,        1'b1, 2, 0, 0, `MASK_W));
    vecs.push_back(mk("lw10d",  1'b0, 3'b010, 'h10, 32'h0,        32'hABCD_EE34, 1'b0, 2, 1, 0, `MASK_W));
`ifdef LSU_MISALIGN_EN
    vecs.push_back(mk("lh11m",  1'b0, 3'b001, 'h11, 32'h0,        32'hFFFF_CDEE, 1'b0, 3, 2, 0, `MASK_B));
    vecs.push_back(mk("sh13m",  1'b1, 3'b001, 'h13, 32'h0000_9988, 32'h0,        1'b0, 3, 0, 2, `MASK_B));
    vecs.push_back(mk("lw10e",  1'b0, 3'b010, 'h10, 32'h0,        32'h88CD_EE34, 1'b0, 2, 1, 0, `MASK_W));
`else
    vecs.push_back(mk("lh11m",  1'b0, 3'b001, 'h11, 32'h0,        32'h0,         1'b1, 2, 0, 0, `MASK_B));
    vecs.push_back(mk("sh13m",  1'b1, 3'b001, 'h13, 32'h0000_9988, 32'h0,        1'b1, 2, 0, 0, `MASK_B));
    vecs.push_back(mk("lw10e",  1'b0, 3'b010, 'h10, 32'h0,        32'hABCD_EE34, 1'b0, 2, 1, 0, `MASK_W));
`endif

    // Reset and clear the memory model.
    pl_clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 pl_clr = 1'b0;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_mem_ctl", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    check("rst_mem_bus", {32'(mem_mask) | 32'(mem_addr) | mem_wr_data}, 32'd0);
    rst = 1'b1;

    preload(8'h10, 8'h34); preload(8'h11, 8'h12); preload(8'h12, 8'h00); preload(8'h13, 8'h80);

    foreach (vecs[i]) run(vecs[i]);

    // Misaligned word load over bytes 0x11..0x14.
    preload(8'h11, 8'h11); preload(8'h12, 8'h22); preload(8'h13, 8'h33); preload(8'h14, 8'h44);
`ifdef LSU_MISALIGN_EN
    run(mk("lw11m", 1'b0, 3'b010, 'h11, 32'h0, 32'h4433_2211, 1'b0, 5, 4, 0, `MASK_B));
    for (int i = 0; i < 4; i++) begin
      check($sformatf("lw11m_addr%0d", i), 32'(log_addr[i]), 32'h11 + 32'(i));
      check($sformatf("lw11m_mask%0d", i), 32'(log_mask[i]), 32'(`MASK_B));
    end
    run(mk("sw11m", 1'b1, 3'b010, 'h11, 32'hA1B2_C3D4, 32'h0, 1'b0, 5, 0, 4, `MASK_B));
    check("sw11m_mem", {mem[8'h14], mem[8'h13], mem[8'h12], mem[8'h11]}, 32'hA1B2_C3D4);
    // Split across the top of the address space wraps to address 0.
    preload(8'hFF, 8'h5A); preload(8'h00, 8'hC3);
    run(mk("lhu_wrap", 1'b0, 3'b101, 'hFFFF, 32'h0, 32'h0000_C35A, 1'b0, 3, 2, 0, `MASK_B));
    check("lhu_wrap_a0", 32'(log_addr[0]), 32'(AW'('hFFFF)));
    check("lhu_wrap_a1", 32'(log_addr[1]), 32'd0);
`else
    run(mk("lw11m", 1'b0, 3'b010, 'h11, 32'h0, 32'h0, 1'b1, 2, 0, 0, `MASK_B));
    run(mk("sw11m", 1'b1, 3'b010, 'h11, 32'hA1B2_C3D4, 32'h0, 1'b1, 2, 0, 0, `MASK_B));
    check("sw11m_mem", {mem[8'h14], mem[8'h13], mem[8'h12], mem[8'h11]}, 32'h4433_2211);
`endif

    // Reset in the middle of a store: no response, bytes already written stay written.
    preload(8'h11, 8'h00); preload(8'h12, 8'h00); preload(8'h13, 8'h00); preload(8'h14, 8'h00);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_wdata = 32'h4433_2211;
`ifdef LSU_MISALIGN_EN
    req_addr = AW'('h11);
`else
    req_addr = AW'('h14);
`endif
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_wr_active", {31'b0, mem_wr_en}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready", {31'b0, req_ready}, 32'd1);
    check("rstmid_mem_ctl", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    check("rstmid_mem_bus", {32'(mem_mask) | 32'(mem_addr) | mem_wr_data}, 32'd0);
    rst = 1'b1;
    begin
      int seen = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      check("rstmid_no_resp", 32'(seen), 32'd0);
    end
`ifdef LSU_MISALIGN_EN
    check("rstmid_mem", {mem[8'h14], mem[8'h13], mem[8'h12], mem[8'h11]}, 32'h0000_0011);
`else
    check("rstmid_mem", {mem[8'h17], mem[8'h16], mem[8'h15], mem[8'h14]}, 32'h4433_2211);
`endif

    run(mk("lw10_post", 1'b0, 3'b010, 'h10, 32'h0, {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]},
           1'b0, 2, 1, 0, `MASK_W));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
